// File: rtl/bip_dbg_pkg.sv
// Shared definitions for the BIP debug unit: command bytes, FSM encoding and
// frame sizing helper.
package bip_dbg_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_CLEAR = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_DUMP_LOAD = 3'd3,
    ST_DUMP_SEND = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_HALTED    = 3'd6
  } state_e;

  // Bytes needed to carry a field of width w, zero-extended.
  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/bip_dbg_frame_tx.sv
// Dump frame transmitter: snapshot shift register, byte counter and the
// tx_start/tx_done handshake with the UART.
module bip_dbg_frame_tx
  import bip_dbg_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic [8*NB-1:0] frame_i,
  input  logic            start_ok_i,
  input  logic            tx_done_i,
  output logic [7:0]      tx_data_o,
  output logic            tx_start_o,
  output logic            frame_done_o
);

  localparam int CNTW = $clog2(NB + 1);

  logic [8*NB-1:0] sreg_q, sreg_d;
  logic [CNTW-1:0] left_q, left_d;
  logic            wait_q, wait_d;
  logic            byte_acked;

  assign tx_data_o    = sreg_q[8*NB-1 -: 8];
  assign tx_start_o   = start_ok_i & ~wait_q & (left_q != '0);
  // tx_done only counts while a byte is outstanding; stray pulses are ignored.
  assign byte_acked   = tx_done_i & wait_q;
  assign frame_done_o = byte_acked & (left_q == CNTW'(1));

  always_comb begin
    sreg_d = sreg_q;
    left_d = left_q;
    wait_d = wait_q;
    if (load_i) begin
      sreg_d = frame_i;
      left_d = CNTW'(NB);
      wait_d = 1'b0;
    end else if (tx_start_o) begin
      wait_d = 1'b1;
    end else if (byte_acked) begin
      sreg_d = sreg_q << 8;
      left_d = left_q - CNTW'(1);
      wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sreg_q <= '0;
      left_q <= '0;
      wait_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      left_q <= left_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/bip_debug_unit.sv
// Command-driven run controller for the BIP core: run, single-step and state
// dump over the UART byte interface.
//
// state        | meaning
// IDLE         | waiting for a command, core stopped
// RUN          | core enabled every cycle until cpu_halt
// STEP         | core enabled for one cycle
// DUMP_LOAD    | snapshot PC/ACC/count into the frame shifter
// DUMP_SEND    | pulse tx_start for the current byte
// DUMP_WAIT    | wait for tx_done of the current byte
// HALTED       | core has halted; commands only re-dump or clear
module bip_debug_unit
  import bip_dbg_pkg::*;
#(
  parameter int AB = 11,
  parameter int DB = 16,
  parameter int CW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_done_i,
  input  logic          tx_done_i,
  input  logic          cpu_halt_i,
  input  logic [AB-1:0] pc_i,
  input  logic [DB-1:0] acc_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_start_o,
  output logic          cpu_en_o,
  output logic          cpu_clear_o,
  output logic          busy_o
);

  localparam int NA = nbytes(AB);
  localparam int ND = nbytes(DB);
  localparam int NC = nbytes(CW);
  localparam int NB = NA + ND + NC;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clear_q, clear_d;
  logic            load, start_ok, frame_done;
  logic [8*NA-1:0] pc_ext;
  logic [8*ND-1:0] acc_ext;
  logic [8*NC-1:0] cnt_ext;

  always_comb begin
    pc_ext  = '0;
    acc_ext = '0;
    cnt_ext = '0;
    pc_ext[AB-1:0]  = pc_i;
    acc_ext[DB-1:0] = acc_i;
    cnt_ext[CW-1:0] = cnt_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_d  = 1'b0;
    cpu_en_o = 1'b0;
    load     = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (rx_done_i) begin
          case (rx_data_i)
            // A halted core cannot advance, so run/step collapse to a dump.
            CMD_RUN:   state_d = (state_q == ST_HALTED) ? ST_DUMP_LOAD : ST_RUN;
            CMD_STEP:  state_d = (state_q == ST_HALTED) ? ST_DUMP_LOAD : ST_STEP;
            CMD_DUMP:  state_d = ST_DUMP_LOAD;
            CMD_CLEAR: begin
              clear_d = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cpu_en_o = ~cpu_halt_i;
        if (cpu_halt_i) state_d = ST_DUMP_LOAD;
      end
      ST_STEP: begin
        cpu_en_o = ~cpu_halt_i;
        state_d  = ST_DUMP_LOAD;
      end
      ST_DUMP_LOAD: begin
        load    = 1'b1;
        state_d = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        start_ok = 1'b1;
        state_d  = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (frame_done)     state_d = cpu_halt_i ? ST_HALTED : ST_IDLE;
        else if (tx_done_i) state_d = ST_DUMP_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cpu_en_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clear_q <= clear_d;
    end
  end

  // Reset itself clears the core, without waiting for a registered pulse.
  assign cpu_clear_o = reset_i | clear_q;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_HALTED);

  bip_dbg_frame_tx #(.NB(NB)) u_frame_tx (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (load),
    .frame_i      ({pc_ext, acc_ext, cnt_ext}),
    .start_ok_i   (start_ok),
    .tx_done_i    (tx_done_i),
    .tx_data_o    (tx_data_o),
    .tx_start_o   (tx_start_o),
    .frame_done_o (frame_done)
  );

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench for bip_debug_unit: a small core model and UART responder
// feed the unit, captured dump frames are compared with hand-computed values.
module tb_bip_debug_unit;
  import bip_dbg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default widths: 2+2+4 byte frame)
  logic        reset, rx_done, tx_done, cpu_halt, tx_start, cpu_en, cpu_clear, busy;
  logic [7:0]  rx_data, tx_data;
  logic [10:0] pc, halt_at;
  logic [15:0] acc;
  logic        halt_en;

  // Narrow-counter instance (CW=8: 2+2+1 byte frame) for the wrap case
  logic        reset2, rx_done2, tx_done2, cpu_halt2, tx_start2, cpu_en2, cpu_clear2, busy2;
  logic [7:0]  rx_data2, tx_data2;
  logic [10:0] pc2;
  logic [15:0] acc2;
  logic        halt2_en;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int resp = 0;
  int resp2 = 0;
  byte unsigned cap[$];
  byte unsigned cap2[$];

  bip_debug_unit dut (
    .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .rx_done_i(rx_done),
    .tx_done_i(tx_done), .cpu_halt_i(cpu_halt), .pc_i(pc), .acc_i(acc),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .cpu_en_o(cpu_en),
    .cpu_clear_o(cpu_clear), .busy_o(busy)
  );

  bip_debug_unit #(.CW(8)) dut2 (
    .clk_i(clk), .reset_i(reset2), .rx_data_i(rx_data2), .rx_done_i(rx_done2),
    .tx_done_i(tx_done2), .cpu_halt_i(cpu_halt2), .pc_i(pc2), .acc_i(acc2),
    .tx_data_o(tx_data2), .tx_start_o(tx_start2), .cpu_en_o(cpu_en2),
    .cpu_clear_o(cpu_clear2), .busy_o(busy2)
  );

  // Core model: PC advances once per enabled cycle, halts at a chosen PC.
  always @(posedge clk) begin
    if (cpu_clear)   pc <= '0;
    else if (cpu_en) pc <= pc + 11'd1;
    if (cpu_clear2)   pc2 <= '0;
    else if (cpu_en2) pc2 <= pc2 + 11'd1;
  end
  assign cpu_halt  = halt_en && (pc == halt_at);
  assign cpu_halt2 = halt2_en && (pc2 == 11'd255);

  // UART model: capture each started byte, acknowledge three cycles later.
  always @(negedge clk) begin
    if (cpu_en) en_cnt++;
    tx_done  = 1'b0;
    tx_done2 = 1'b0;
    if (tx_start) begin
      cap.push_back(tx_data);
      resp = 3;
    end else if (resp != 0) begin
      resp--;
      if (resp == 0) tx_done = 1'b1;
    end
    if (tx_start2) begin
      cap2.push_back(tx_data2);
      resp2 = 3;
    end else if (resp2 != 0) begin
      resp2--;
      if (resp2 == 0) tx_done2 = 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_cmd(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin rx_data2 = b; rx_done2 = 1'b1; end
    else     begin rx_data  = b; rx_done  = 1'b1; end
    @(negedge clk);
    rx_done  = 1'b0;
    rx_done2 = 1'b0;
  endtask

  task automatic check_frame(input string tag, input bit sel, input int nb, input logic [63:0] exp);
    logic [63:0] got;
    int n;
    got = '0;
    for (int i = 0; i < 800; i++) begin
      if (!sel && cap.size() >= nb && !busy) break;
      if (sel && cap2.size() >= nb && !busy2) break;
      @(negedge clk);
    end
    n = sel ? cap2.size() : cap.size();
    check_val({tag, "_len"}, 64'(n), 64'(nb));
    for (int k = 0; k < nb && k < n; k++) got = {got[55:0], (sel ? cap2[k] : cap[k])};
    check_val(tag, got, exp);
    if (sel) cap2.delete();
    else     cap.delete();
  endtask

  task automatic wait_bytes(input bit sel, input int nb);
    for (int i = 0; i < 800; i++) begin
      if (!sel && cap.size() >= nb) break;
      if (sel && cap2.size() >= nb) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int e0;
    reset = 1'b1; rx_done = 1'b0; rx_data = '0; acc = '0; halt_en = 1'b0; halt_at = '0;
    reset2 = 1'b1; rx_done2 = 1'b0; rx_data2 = '0; acc2 = 16'hC0DE; halt2_en = 1'b0;

    // 1: reset values, then an all-zero dump
    repeat (3) @(negedge clk);
    check_val("rst_clear", 64'(cpu_clear), 64'd1);
    check_val("rst_tx_start", 64'(tx_start), 64'd0);
    check_val("rst_cpu_en", 64'(cpu_en), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_tx_data", 64'(tx_data), 64'd0);
    reset = 1'b0; reset2 = 1'b0;
    @(negedge clk);
    check_val("post_rst_clear", 64'(cpu_clear), 64'd0);
    send_cmd(0, CMD_DUMP);
    check_frame("t1_frame", 0, 8, 64'h0000_0000_0000_0000);
    check_val("t1_state", 64'(dut.state_q), 64'(ST_IDLE));

    // 2: run until halt after five instructions
    acc = 16'h1234; halt_at = 11'd5; halt_en = 1'b1;
    e0 = en_cnt;
    send_cmd(0, CMD_RUN);
    check_val("t2_en_latency", 64'(cpu_en), 64'd1);
    check_frame("t2_frame", 0, 8, 64'h0005_1234_0000_0005);
    check_val("t2_en_cycles", 64'(en_cnt - e0), 64'd5);
    check_val("t2_state", 64'(dut.state_q), 64'(ST_HALTED));

    // 3: clear, then three single steps
    halt_en = 1'b0; acc = 16'h00AA;
    send_cmd(0, CMD_CLEAR);
    check_val("t3_clear_pulse", 64'(cpu_clear), 64'd1);
    for (int s = 1; s <= 3; s++) begin
      e0 = en_cnt;
      send_cmd(0, CMD_STEP);
      check_frame($sformatf("t3_step%0d", s), 0, 8, {16'(s), 16'h00AA, 32'(s)});
      check_val($sformatf("t3_en%0d", s), 64'(en_cnt - e0), 64'd1);
    end

    // 4: step while halted does not advance
    halt_at = 11'd3; halt_en = 1'b1;
    e0 = en_cnt;
    send_cmd(0, CMD_STEP);
    check_frame("t4_frame", 0, 8, 64'h0003_00AA_0000_0003);
    check_val("t4_no_en", 64'(en_cnt - e0), 64'd0);
    check_val("t4_state", 64'(dut.state_q), 64'(ST_HALTED));

    // 5: run command arriving mid-dump is ignored
    halt_en = 1'b0;
    send_cmd(0, CMD_CLEAR);
    send_cmd(0, CMD_DUMP);
    wait_bytes(0, 1);
    e0 = en_cnt;
    send_cmd(0, CMD_RUN);
    check_frame("t5_frame", 0, 8, 64'h0000_00AA_0000_0000);
    check_val("t5_no_en", 64'(en_cnt - e0), 64'd0);
    check_val("t5_state", 64'(dut.state_q), 64'(ST_IDLE));

    // 6: reset after the third byte aborts the frame
    acc = 16'h0BEE;
    send_cmd(0, CMD_STEP);
    check_frame("t6_pre", 0, 8, 64'h0001_0BEE_0000_0001);
    send_cmd(0, CMD_DUMP);
    wait_bytes(0, 3);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_val("t6_no_more_bytes", 64'(cap.size()), 64'd3);
    check_val("t6_busy", 64'(busy), 64'd0);
    check_val("t6_cpu_en", 64'(cpu_en), 64'd0);
    check_val("t6_state", 64'(dut.state_q), 64'(ST_IDLE));
    cap.delete();
    send_cmd(0, CMD_DUMP);
    check_frame("t6_count_zero", 0, 8, 64'h0000_0BEE_0000_0000);

    // 7: narrow counter reaches all-ones, one more step wraps it to zero
    halt2_en = 1'b1;
    send_cmd(1, CMD_RUN);
    wait_bytes(1, 1);
    halt2_en = 1'b0;
    check_frame("t7_full", 1, 5, 64'h00_00FF_C0DE_FF);
    check_val("t7_state", 64'(dut2.state_q), 64'(ST_IDLE));
    send_cmd(1, CMD_STEP);
    check_frame("t7_wrap", 1, 5, 64'h00_0100_C0DE_00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
